// File: rtl/monster_pkg.sv
// Shared monster-lane definitions: spawner FSM states, lane geometry and X mapping.
package monster_pkg;

    typedef enum logic [1:0] {
        WAIT_CLEAR = 2'd0,
        ACCUM      = 2'd1,
        SPAWN      = 2'd2,
        WAIT_ACK   = 2'd3
    } spawn_state_t;

    localparam int unsigned COORD_W   = 10;
    localparam int unsigned ACC_W     = 16;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned LFSR_W    = 16;

    localparam int unsigned X_MIN     = 170;
    localparam int unsigned X_MAX     = 469;
    localparam int unsigned MONSTER_W = 39;
    localparam int unsigned SPAWN_Y   = 10;

    // Usable left-edge positions; must stay within 256..511 so one subtract folds a 9-bit draw.
    localparam int unsigned SPAN      = X_MAX - X_MIN + 1 - MONSTER_W;

    function automatic logic [COORD_W-1:0] map_x(input logic [8:0] r);
        logic [COORD_W-1:0] rx;
        logic [COORD_W-1:0] off;
        rx  = COORD_W'(r);
        off = (rx >= COORD_W'(SPAN)) ? rx - COORD_W'(SPAN) : rx;
        return COORD_W'(X_MIN) + off;
    endfunction

endpackage

// File: rtl/monster_spawner_lfsr16.sv
// 16-bit right-shifting Galois LFSR, free-running outside reset.
module lfsr16 #(
    parameter logic [15:0] TAPS = 16'hB400
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            q <= seed;
        end else begin
            q <= (q >> 1) ^ (q[0] ? TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/monster_spawner.sv
// Decides when a monster enters the playfield and where; re-pulses gene until appear acknowledges.
module monster_spawner
    import monster_pkg::*;
#(
    parameter logic [ACC_W-1:0]  SPAWN_DIST     = 16'd600,
    parameter logic [CNT_W-1:0]  MIN_GAP_FRAMES = 8'd120,
    parameter logic [CNT_W-1:0]  ACK_TIMEOUT    = 8'd4,
    parameter logic [LFSR_W-1:0] LFSR_SEED      = 16'hACE1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic [9:0]         distance,
    input  logic               appear,
    output logic               gene,
    output logic [COORD_W-1:0] spawn_x,
    output logic [COORD_W-1:0] spawn_y,
    output logic [CNT_W-1:0]   spawn_count,
    output logic [1:0]         state_o
);

    spawn_state_t        state;
    logic                fclk_d;
    logic                armed;
    logic                ftick_c;
    logic [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]    gap_cnt;
    logic [CNT_W-1:0]    ack_cnt;
    logic [LFSR_W-1:0]   lfsr;
    logic [ACC_W:0]      acc_sum_c;
    logic [ACC_W-1:0]    acc_sat_c;
    logic                spawn_ok_c;

    lfsr16 #(.TAPS(16'hB400)) u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .seed  (LFSR_SEED),
        .q     (lfsr)
    );

    // armed masks the first post-reset cycle so a frame_clk already high is not seen as an edge
    assign ftick_c    = frame_clk & ~fclk_d & armed;
    assign acc_sum_c  = (ACC_W+1)'(acc) + (ACC_W+1)'(distance);
    assign acc_sat_c  = acc_sum_c[ACC_W] ? {ACC_W{1'b1}} : acc_sum_c[ACC_W-1:0];
    assign spawn_ok_c = (acc >= SPAWN_DIST) && (gap_cnt >= MIN_GAP_FRAMES);
    assign state_o    = state;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= WAIT_CLEAR;
            fclk_d      <= 1'b0;
            armed       <= 1'b0;
            acc         <= '0;
            gap_cnt     <= MIN_GAP_FRAMES;
            ack_cnt     <= '0;
            gene        <= 1'b0;
            spawn_x     <= COORD_W'(X_MIN);
            spawn_y     <= COORD_W'(SPAWN_Y);
            spawn_count <= '0;
        end else begin
            fclk_d <= frame_clk;
            armed  <= 1'b1;
            gene   <= 1'b0;

            if (ftick_c && (gap_cnt != {CNT_W{1'b1}})) begin
                gap_cnt <= gap_cnt + CNT_W'(1);
            end

            case (state)
                WAIT_CLEAR: begin
                    acc <= '0;
                    if (!appear) begin
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (appear) begin
                        state <= WAIT_CLEAR;
                        acc   <= '0;
                    end else if (spawn_ok_c) begin
                        state       <= SPAWN;
                        gene        <= 1'b1;
                        spawn_x     <= map_x(lfsr[8:0]);
                        spawn_count <= spawn_count + CNT_W'(1);
                    end else if (ftick_c) begin
                        acc <= acc_sat_c;
                    end
                end
                SPAWN: begin
                    acc     <= '0;
                    gap_cnt <= '0;
                    ack_cnt <= '0;
                    state   <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    // appear outranks the timeout when both land together
                    if (appear) begin
                        state <= WAIT_CLEAR;
                    end else if (ack_cnt >= ACK_TIMEOUT) begin
                        state       <= SPAWN;
                        gene        <= 1'b1;
                        spawn_x     <= map_x(lfsr[8:0]);
                        spawn_count <= spawn_count + CNT_W'(1);
                    end else if (ftick_c) begin
                        ack_cnt <= ack_cnt + CNT_W'(1);
                    end
                end
                default: state <= WAIT_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_monster_spawner.sv
// Directed bench for monster_spawner: reset, accumulate/spawn, ack retry, gap, saturation, mid-spawn reset.
module tb_monster_spawner;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic [9:0] distance;
    logic       appear;
    logic       gene;
    logic [9:0] spawn_x;
    logic [9:0] spawn_y;
    logic [7:0] spawn_count;
    logic [1:0] state_o;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int gene_cnt = 0;
    int last_gene_cyc = -1;
    int dbl_gene = 0;
    int tick_cyc = 0;
    int ticks_since = 0;
    logic prev_gene = 1'b0;

    localparam logic [1:0] S_WAIT_CLEAR = 2'd0;
    localparam logic [1:0] S_SPAWN      = 2'd2;
    localparam logic [1:0] S_WAIT_ACK   = 2'd3;

    monster_spawner dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .distance    (distance),
        .appear      (appear),
        .gene        (gene),
        .spawn_x     (spawn_x),
        .spawn_y     (spawn_y),
        .spawn_count (spawn_count),
        .state_o     (state_o)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc_n <= cyc_n + 1;

    always @(negedge Clk) begin
        if (gene === 1'b1) begin
            gene_cnt++;
            last_gene_cyc = cyc_n;
            if (prev_gene === 1'b1) dbl_gene++;
        end
        prev_gene = gene;
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    // one frame tick: frame_clk high for one cycle, then three low cycles
    task automatic tick();
        frame_clk = 1'b1;
        tick_cyc  = cyc_n;
        cyc();
        frame_clk = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        Reset     = 1'b1;
        appear    = 1'b1;
        frame_clk = 1'b0;
        distance  = 10'd0;

        // reset with frame_clk toggling, released while frame_clk is high
        cyc(); frame_clk = 1'b1;
        cyc(); frame_clk = 1'b0;
        cyc(); frame_clk = 1'b1;
        chk("rst_gene",  32'(gene), 32'd0);
        chk("rst_x",     32'(spawn_x), 32'd170);
        chk("rst_y",     32'(spawn_y), 32'd10);
        chk("rst_count", 32'(spawn_count), 32'd0);
        chk("rst_state", 32'(state_o), 32'(S_WAIT_CLEAR));
        Reset = 1'b0;
        cyc(); cyc();
        chk("rst_no_tick_gap", 32'(dut.gap_cnt), 32'd120);
        frame_clk = 1'b0;

        // accumulate 100 per tick; crossing on the 6th tick, forced draw 300 -> x=209
        appear   = 1'b0;
        distance = 10'd100;
        force dut.lfsr = 16'd300;
        cyc(); cyc();
        repeat (5) tick();
        chk("acc_500",        32'(dut.acc), 32'd500);
        chk("no_gene_5ticks", 32'(gene_cnt), 32'd0);
        tick();
        chk("gene1_count",  32'(gene_cnt), 32'd1);
        chk("gene1_timing", 32'(last_gene_cyc), 32'(tick_cyc + 2));
        chk("gene1_x",      32'(spawn_x), 32'd209);
        chk("gene1_scount", 32'(spawn_count), 32'd1);
        chk("gene1_state",  32'(state_o), 32'(S_WAIT_ACK));

        // no ack: re-pulse after exactly 4 ticks with a fresh draw 260 -> x=430
        force dut.lfsr = 16'd260;
        repeat (3) tick();
        chk("ack_wait_3", 32'(gene_cnt), 32'd1);
        tick();
        chk("retry_count",  32'(gene_cnt), 32'd2);
        chk("retry_timing", 32'(last_gene_cyc), 32'(tick_cyc + 2));
        chk("retry_x",      32'(spawn_x), 32'd430);
        chk("retry_scount", 32'(spawn_count), 32'd2);
        release dut.lfsr;

        // appear raised on the 4th tick wins over the timeout
        repeat (3) tick();
        appear = 1'b1;
        tick();
        chk("ack_appear_gene",  32'(gene_cnt), 32'd2);
        chk("ack_appear_state", 32'(state_o), 32'(S_WAIT_CLEAR));
        ticks_since = 4;

        // gap enforcement, with accumulator saturation along the way
        repeat (2) tick();
        ticks_since += 2;
        appear   = 1'b0;
        distance = 10'd1023;
        cyc(); cyc();
        for (int k = ticks_since + 1; k <= 120; k++) begin
            tick();
            if (k == ticks_since + 70) chk("acc_sat", 32'(dut.acc), 32'hFFFF);
            if (k == 119) chk("gap_block", 32'(gene_cnt), 32'd2);
        end
        chk("gap_gene_count",  32'(gene_cnt), 32'd3);
        chk("gap_gene_timing", 32'(last_gene_cyc), 32'(tick_cyc + 2));
        chk("gap_scount",      32'(spawn_count), 32'd3);
        chk("gap_x_in_lane",   32'((spawn_x >= 10'd170) && (spawn_x <= 10'd430)), 32'd1);

        // reset asserted in the SPAWN cycle of a retry
        repeat (3) tick();
        frame_clk = 1'b1;
        cyc();
        frame_clk = 1'b0;
        cyc();
        chk("pre_rst_gene",  32'(gene), 32'd1);
        chk("pre_rst_state", 32'(state_o), 32'(S_SPAWN));
        Reset = 1'b1;
        cyc();
        chk("mid_rst_gene",  32'(gene), 32'd0);
        chk("mid_rst_count", 32'(spawn_count), 32'd0);
        chk("mid_rst_state", 32'(state_o), 32'(S_WAIT_CLEAR));
        chk("mid_rst_acc",   32'(dut.acc), 32'd0);
        chk("mid_rst_x",     32'(spawn_x), 32'd170);
        Reset = 1'b0;
        repeat (3) cyc();

        chk("no_double_gene", 32'(dbl_gene), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
